vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the VGA running-line pipeline; drives the pixel painter directly.
//  Generates pixel coordinates sx/sy, active-area flag data_en and line/frame strobes.
//  Also produces a frame counter and hsync/vsync/de outputs.
//  The sync/de outputs are delayed to line up with the registered RGB leaving the painter stage.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  H_POL     0    hsync active level (0 = active-low)
//  V_POL     0    vsync active level (0 = active-low)
//  PIPE_DLY  1    clk_pix cycles of delay on vga_hsync/vga_vsync/vga_de (0..8)
// PORTS
//  clk_pix      in   1   pixel clock, 25 MHz nominal
//  rst          in   1   asynchronous reset, active-high
//  sx           out  10  horizontal position, 0..H_TOTAL-1
//  sy           out  10  vertical position, 0..V_TOTAL-1
//  data_en      out  1   1 when sx<H_ACTIVE and sy<V_ACTIVE
//  line_start   out  1   1-cycle pulse when sx==0
//  frame_start  out  1   1-cycle pulse when sx==0 and sy==0
//  frame_cnt    out  16  frame index, wraps modulo 2^16
//  vga_hsync    out  1   hsync, delayed PIPE_DLY cycles
//  vga_vsync    out  1   vsync, delayed PIPE_DLY cycles
//  vga_de       out  1   data_en, delayed PIPE_DLY cycles
// BEHAVIOUR
//  - Reset is rst, asynchronous, active-high; clock is clk_pix. All outputs are registered.
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
//  - Elaboration error if H_TOTAL>1024, V_TOTAL>1024, or PIPE_DLY>8.
//  - Reset values:
//      sx=H_TOTAL-1, sy=V_TOTAL-1, frame_cnt=16'hFFFF.
//      data_en, line_start and frame_start are 0.
//      hsync/vsync sit at their inactive level (~H_POL / ~V_POL); the vga_* delay taps hold the same idle values.
//  - Counting: sx increments every cycle. When sx==H_TOTAL-1, sx returns to 0 and sy increments.
//    When sy==V_TOTAL-1 on that same wrap, sy returns to 0.
//  - All flags are computed from the NEXT counter values, so they align with sx/sy on the same cycle. Latency is 0 relative to sx/sy.
//  - hsync is active for H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC (656..751).
//  - vsync is active for V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC (490..491), across full lines.
//  - frame_cnt increments on the edge that produces frame_start. The first frame after reset therefore reads 0.
//  - First clk_pix edge after rst deasserts gives sx=0, sy=0, data_en=1, line_start=1, frame_start=1, frame_cnt=0.
//  - Reset mid-frame: all outputs go to their reset values immediately (async). Restart is as above, with no partial frame.
//  - Delay line:
//      vga_* equal the internal hsync/vsync/de delayed exactly PIPE_DLY cycles.
//      PIPE_DLY=0 is a direct wire from the registered values.
//  - No back-pressure or handshake; the timing free-runs.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//      640x480@60 timing localparams (H_*, V_*, H_TOTAL, V_TOTAL);
//      typedef logic [9:0] coord_t;
//      localparam PIX_CLK_HZ = 25_000_000 (shared with the message painter's scroll divider).
//  - Sub-module sync_delay_line #(WIDTH=3, DEPTH=PIPE_DLY, RST_VAL):
//      a shift register with async reset to RST_VAL;
//      generate-bypassed when DEPTH==0.
//  - Top module: the two counters, the flag decode and frame_cnt.
// TESTING
//  1. Release rst -> first edge: sx=0, sy=0, data_en=1, line_start=1, frame_start=1, frame_cnt=0, vga_de=0 (PIPE_DLY=1), then vga_de=1 one cycle later.
//  2. One line -> data_en high exactly 640 cycles (sx 0..639), low 160. hsync low exactly 96 cycles starting at sx=656. line_start period 800.
//  3. One frame -> vsync low for exactly 1600 cycles (sy 490..491). frame_start period 420000 cycles. sy never reaches 525.
//  4. Run 3 frames -> frame_cnt=2 during the third frame. Force frame_cnt=16'hFFFF -> wraps to 0 on the next frame_start.
//  5. PIPE_DLY=0 and PIPE_DLY=3 -> vga_hsync/vga_vsync/vga_de match the internal values exactly 0 / 3 cycles later.
//  6. Assert rst at sx=300, sy=100 -> all outputs at reset values the same cycle. On release, scenario 1 repeats exactly.
//  Checker: a reference model compares sx/sy/flags every cycle for >=2 full frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate type for the VGA running-line pipeline.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned PIX_CLK_HZ = 25_000_000;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for sync/de bits; DEPTH==0 degenerates to a wire.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned          WIDTH   = 3,
  parameter int unsigned          DEPTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = clk_pix ^ rst;
    assign o_q      = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
      end else begin
        r_sr[0] <= i_d;
        for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    end

    assign o_q = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with registered flags, frame counter and delayed sync/de outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        clk_pix,
  input  logic        rst,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        data_en,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1024) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOT > 1024) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (PIPE_DLY > 8) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY exceeds 8");
  end

  localparam coord_t SX_LAST = coord_t'(H_TOT - 1);
  localparam coord_t SY_LAST = coord_t'(V_TOT - 1);
  localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t      r_sx, r_sy;
  coord_t      w_sx_nxt, w_sy_nxt;
  logic        r_de, r_ls, r_fs, r_hs, r_vs;
  logic        w_de, w_ls, w_fs, w_hs, w_vs;
  logic [15:0] r_frame_cnt;
  logic [2:0]  w_dly_out;

  // Flags decode the next counter values so they register alongside sx/sy.
  always_comb begin
    w_sx_nxt = (r_sx == SX_LAST) ? '0 : r_sx + coord_t'(1);
    w_sy_nxt = r_sy;
    if (r_sx == SX_LAST) w_sy_nxt = (r_sy == SY_LAST) ? '0 : r_sy + coord_t'(1);
    w_de = (w_sx_nxt < H_ACT_C) && (w_sy_nxt < V_ACT_C);
    w_ls = (w_sx_nxt == '0);
    w_fs = w_ls && (w_sy_nxt == '0);
    w_hs = ((w_sx_nxt >= HS_BEG) && (w_sx_nxt < HS_END)) ? H_POL : ~H_POL;
    w_vs = ((w_sy_nxt >= VS_BEG) && (w_sy_nxt < VS_END)) ? V_POL : ~V_POL;
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_sx        <= SX_LAST;
      r_sy        <= SY_LAST;
      r_de        <= 1'b0;
      r_ls        <= 1'b0;
      r_fs        <= 1'b0;
      r_hs        <= ~H_POL;
      r_vs        <= ~V_POL;
      r_frame_cnt <= '1;
    end else begin
      r_sx <= w_sx_nxt;
      r_sy <= w_sy_nxt;
      r_de <= w_de;
      r_ls <= w_ls;
      r_fs <= w_fs;
      r_hs <= w_hs;
      r_vs <= w_vs;
      if (w_fs) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  sync_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DLY),
    .RST_VAL({~H_POL, ~V_POL, 1'b0})
  ) u_dly (
    .clk_pix(clk_pix),
    .rst    (rst),
    .i_d    ({r_hs, r_vs, r_de}),
    .o_q    (w_dly_out)
  );

  assign sx          = r_sx;
  assign sy          = r_sy;
  assign data_en     = r_de;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign frame_cnt   = r_frame_cnt;
  assign vga_hsync   = w_dly_out[2];
  assign vga_vsync   = w_dly_out[1];
  assign vga_de      = w_dly_out[0];

endmodule
